// File: rtl/qspi_flash_writer.sv
// qspi_flash_writer
//   Sequencer in front of qspi_mem_controller. It takes a byte stream together
//   with a start address and a length, and programs that data into flash. Each
//   sector the job enters is erased first (WREN+SE). Incoming bytes are gathered
//   into a 256-byte page, and each page is written with WREN+PP.
//
// Ports
//   CLK_100M, RESET_N        clock and asynchronous active-low reset
//   start, start_addr,       job request (sampled in IDLE only). The address
//   length                   must be page aligned, and length is 0..2^24 bytes.
//   s_data/s_valid/s_ready   byte stream. A byte is taken on s_valid && s_ready.
//   busy, done, error,       job status. done is a one-cycle pulse. error and
//   err_code                 err_code hold until the next start is accepted.
//                            err_code: 1 misaligned, 2 range,
//                            3 controller error.
//   mem_trigger, mem_quad,   command interface to the controller
//   mem_cmd, mem_addr,
//   mem_data
//   mem_busy, mem_error      controller status
//
// state      | meaning
// IDLE       | waiting for start
// CHECK      | validate the latched job parameters
// ERASE_WREN | write-enable ahead of sector erase
// ERASE_SE   | sector erase at cur_addr
// FILL       | accept stream bytes into the page buffer
// PAD        | stream exhausted; complete the page with 0xFF
// PROG_WREN  | write-enable ahead of page program
// PROG_PP    | page program of the buffer at cur_addr
// NEXT       | advance to the next page, or stop
// FINISH     | pulse done, then return to IDLE

module qspi_flash_writer #(
  parameter int SECTOR_BITS = 16,
  parameter bit ERASE_EN    = 1'b1,
  parameter bit QUAD        = 1'b0
) (
  input  logic          CLK_100M,
  input  logic          RESET_N,
  input  logic          start,
  input  logic [23:0]   start_addr,
  input  logic [24:0]   length,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic          mem_trigger,
  output logic          mem_quad,
  output logic [7:0]    mem_cmd,
  output logic [23:0]   mem_addr,
  output logic [2047:0] mem_data,
  input  logic          mem_busy,
  input  logic          mem_error
);

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_PP   = 8'h02;

  typedef enum logic [3:0] {
    IDLE, CHECK, ERASE_WREN, ERASE_SE, FILL, PAD, PROG_WREN, PROG_PP, NEXT, FINISH
  } state_t;

  state_t          state;
  state_t          cmd_next;
  logic [1:0]      phase;       // 0 wait idle + trigger, 1 wait busy, 2 wait done
  logic [23:0]     cur_addr;
  logic [24:0]     remaining;
  logic [8:0]      page_cnt;
  logic [2047:0]   page_buf;
  logic [7:0]      cmd_op;
  logic [24:0]     end_addr;
  logic [23:0]     next_addr;
  logic            erase_next;

  assign end_addr   = {1'b0, cur_addr} + remaining;
  assign next_addr  = cur_addr + 24'd256;
  assign erase_next = ERASE_EN && (next_addr[SECTOR_BITS-1:0] == '0);
  assign s_ready    = (state == FILL) && (page_cnt != 9'd256) && (remaining != 25'd0);
  assign mem_quad   = QUAD;

  always_comb begin
    cmd_op   = CMD_WREN;
    cmd_next = IDLE;
    case (state)
      ERASE_WREN: cmd_next = ERASE_SE;
      ERASE_SE: begin
        cmd_op   = CMD_SE;
        cmd_next = FILL;
      end
      PROG_WREN: cmd_next = PROG_PP;
      PROG_PP: begin
        cmd_op   = CMD_PP;
        cmd_next = NEXT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_100M or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      phase       <= 2'd0;
      cur_addr    <= '0;
      remaining   <= '0;
      page_cnt    <= '0;
      page_buf    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'd0;
      mem_trigger <= 1'b0;
      mem_cmd     <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
    end else begin
      mem_trigger <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            remaining <= length;
            error     <= 1'b0;
            err_code  <= 2'd0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (cur_addr[7:0] != 8'd0) begin
            err_code <= 2'd1;
            error    <= 1'b1;
            done     <= 1'b1;
            state    <= FINISH;
          end else if (end_addr > 25'h100_0000) begin
            err_code <= 2'd2;
            error    <= 1'b1;
            done     <= 1'b1;
            state    <= FINISH;
          end else if (remaining == 25'd0) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            page_cnt <= '0;
            phase    <= 2'd0;
            // The first page of a job is erased even if it is mid-sector.
            state    <= ERASE_EN ? ERASE_WREN : FILL;
          end
        end
        ERASE_WREN, ERASE_SE, PROG_WREN, PROG_PP: begin
          case (phase)
            2'd0: begin
              if (!mem_busy) begin
                mem_trigger <= 1'b1;
                mem_cmd     <= cmd_op;
                mem_addr    <= cur_addr;
                if (state == PROG_WREN || state == PROG_PP) mem_data <= page_buf;
                phase <= 2'd1;
              end
            end
            2'd1: if (mem_busy) phase <= 2'd2;
            default: begin
              if (!mem_busy) begin
                phase <= 2'd0;
                if (mem_error) begin
                  err_code <= 2'd3;
                  error    <= 1'b1;
                  done     <= 1'b1;
                  state    <= FINISH;
                end else begin
                  state <= cmd_next;
                end
              end
            end
          endcase
        end
        FILL: begin
          if (page_cnt == 9'd256) begin
            state <= PROG_WREN;
          end else if (remaining == 25'd0) begin
            state <= PAD;
          end else if (s_valid && s_ready) begin
            page_buf  <= {page_buf[2039:0], s_data};
            remaining <= remaining - 25'd1;
            page_cnt  <= page_cnt + 9'd1;
          end
        end
        PAD: begin
          if (page_cnt == 9'd256) begin
            state <= PROG_WREN;
          end else begin
            page_buf <= {page_buf[2039:0], 8'hFF};
            page_cnt <= page_cnt + 9'd1;
          end
        end
        NEXT: begin
          cur_addr <= next_addr;
          if (remaining != 25'd0) begin
            page_cnt <= '0;
            state    <= erase_next ? ERASE_WREN : FILL;
          end else begin
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
